regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb.sv | 61 ++++++
 tb/tb_regfile_wb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Register file for the writeback stage: 31 writable registers plus a
// hard-wired zero, two read ports with optional write-through bypass,
// a bypass-free debug read port and a counter of committed writes.
module regfile_wb #(
    parameter int RBYPASS = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wwreg,
    input  logic             wm2reg,
    input  logic [4:0]       wtemp,
    input  logic [31:0]      wr,
    input  logic [31:0]      wdo,
    input  logic [4:0]       rna,
    input  logic [4:0]       rnb,
    output logic [31:0]      qa,
    output logic [31:0]      qb,
    output logic [31:0]      wdata,
    input  logic [4:0]       dbg_rn,
    output logic [31:0]      dbg_q,
    output logic [CNT_W-1:0] wb_count
);

    logic [31:0] regs [32];
    logic        commit;

    // Writeback source select and commit qualification. The commit is gated
    // by clrn so the bypass path is also silenced while reset is held.
    always_comb begin
        wdata  = wm2reg ? wdo : wr;
        commit = clrn && wwreg && (wtemp != 5'd0);
    end

    // Storage and commit counter; entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[wtemp] <= wdata;
            wb_count    <= wb_count + CNT_W'(1);
        end
    end

    // Read ports: zero register forced, bypass only on A/B, never on debug.
    always_comb begin
        qa    = (rna == 5'd0) ? 32'd0 : regs[rna];
        qb    = (rnb == 5'd0) ? 32'd0 : regs[rnb];
        dbg_q = (dbg_rn == 5'd0) ? 32'd0 : regs[dbg_rn];
        if (RBYPASS != 0 && commit && wtemp == rna) begin
            qa = wdata;
        end
        if (RBYPASS != 0 && commit && wtemp == rnb) begin
            qb = wdata;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb. Three instances share the stimulus:
// default parameters, bypass disabled, and a 4-bit commit counter.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        clrn, wwreg, wm2reg;
    logic [4:0]  wtemp, rna, rnb, dbg_rn;
    logic [31:0] wr, wdo;

    logic [31:0] qa0, qb0, wd0, dbg0, cnt0;
    logic [31:0] qa1, qb1, wd1, dbg1, cnt1;
    logic [31:0] qa2, qb2, wd2, dbg2;
    logic [3:0]  cnt2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [32];
    logic [31:0] mcnt;

    regfile_wb dut_byp (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wtemp(wtemp),
        .wr(wr), .wdo(wdo), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
        .wdata(wd0), .dbg_rn(dbg_rn), .dbg_q(dbg0), .wb_count(cnt0));

    regfile_wb #(.RBYPASS(0)) dut_nob (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wtemp(wtemp),
        .wr(wr), .wdo(wdo), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
        .wdata(wd1), .dbg_rn(dbg_rn), .dbg_q(dbg1), .wb_count(cnt1));

    regfile_wb #(.CNT_W(4)) dut_c4 (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wtemp(wtemp),
        .wr(wr), .wdo(wdo), .rna(rna), .rnb(rnb), .qa(qa2), .qb(qb2),
        .wdata(wd2), .dbg_rn(dbg_rn), .dbg_q(dbg2), .wb_count(cnt2));

    always #5 clk = ~clk;

    // Reference model: a plain array of register values and a commit tally.
    function automatic logic [31:0] exp_wdata();
        return wm2reg ? wdo : wr;
    endfunction

    function automatic bit commit_now();
        return clrn && wwreg && (wtemp != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] rn, input bit byp);
        if (byp && commit_now() && wtemp == rn) return exp_wdata();
        return mem[rn];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mcnt = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (commit_now()) begin
            mem[wtemp] = exp_wdata();
            mcnt = mcnt + 32'd1;
        end
        #1;
    endtask

    task automatic idle();
        wwreg = 0; wm2reg = 0; wtemp = 0; wr = 0; wdo = 0;
        rna = 0; rnb = 0; dbg_rn = 0;
    endtask

    task automatic test_reset();
        clrn = 0;
        idle();
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rna = 5; rnb = 31; dbg_rn = 17;
        #1;
        total++; if (cnt0 !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt0); end
        total++; if (cnt2 !== 4'd0) begin bad++; $display("FAIL reset_cnt4 got=%h exp=0", cnt2); end
        total++; if (qa0 !== 32'd0 || qb0 !== 32'd0 || dbg0 !== 32'd0) begin
            bad++; $display("FAIL reset_reads got=%h/%h/%h exp=0", qa0, qb0, dbg0); end
        clrn = 1;
        idle();
        #1;
    endtask

    task automatic test_basic_write();
        wwreg = 1; wm2reg = 0; wtemp = 5; wr = 32'h1234_5678; wdo = 32'h0BAD_0BAD;
        #1;
        total++; if (wd0 !== 32'h1234_5678) begin bad++; $display("FAIL wdata_alu got=%h exp=12345678", wd0); end
        tick();
        wwreg = 0; dbg_rn = 5;
        #1;
        total++; if (dbg0 !== 32'h1234_5678) begin bad++; $display("FAIL write_r5 got=%h exp=12345678", dbg0); end
        total++; if (cnt0 !== 32'd1) begin bad++; $display("FAIL count_one got=%0d exp=1", cnt0); end
    endtask

    task automatic test_bypass();
        wwreg = 1; wm2reg = 1; wtemp = 7; wdo = 32'hDEAD_BEEF; wr = 32'h1;
        rna = 7; dbg_rn = 7;
        #1;
        total++; if (qa0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_qa got=%h exp=deadbeef", qa0); end
        total++; if (dbg0 !== 32'd0) begin bad++; $display("FAIL dbg_no_bypass got=%h exp=0", dbg0); end
        total++; if (qa1 !== 32'd0) begin bad++; $display("FAIL nobyp_qa_old got=%h exp=0", qa1); end
        tick();
        wwreg = 0;
        #1;
        total++; if (dbg0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dbg_after_edge got=%h exp=deadbeef", dbg0); end
    endtask

    task automatic test_reg_zero();
        logic [31:0] c_before;
        c_before = mcnt;
        wwreg = 1; wm2reg = 0; wtemp = 0; wr = 32'hFFFF_FFFF; rna = 0; rnb = 0;
        #1;
        total++; if (qa0 !== 32'd0) begin bad++; $display("FAIL r0_before got=%h exp=0", qa0); end
        tick();
        wwreg = 0;
        #1;
        total++; if (qa0 !== 32'd0 || qb0 !== 32'd0) begin bad++; $display("FAIL r0_after got=%h/%h exp=0", qa0, qb0); end
        total++; if (cnt0 !== c_before) begin bad++; $display("FAIL r0_count got=%0d exp=%0d", cnt0, c_before); end
    endtask

    task automatic test_no_bypass();
        logic [31:0] old3;
        old3 = mem[3];
        wwreg = 1; wm2reg = 0; wtemp = 3; wr = 32'hA5A5_A5A5; rna = 3; rnb = 3;
        #1;
        total++; if (qa1 !== old3 || qb1 !== old3) begin bad++; $display("FAIL nobyp_same_cycle got=%h/%h exp=%h", qa1, qb1, old3); end
        total++; if (qa0 !== 32'hA5A5_A5A5 || qb0 !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL byp_both_ports got=%h/%h exp=a5a5a5a5", qa0, qb0); end
        tick();
        wwreg = 0;
        #1;
        total++; if (qa1 !== 32'hA5A5_A5A5 || qb1 !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL nobyp_next_cycle got=%h/%h exp=a5a5a5a5", qa1, qb1); end
    endtask

    task automatic test_wrap();
        clrn = 0; model_clear(); idle(); #1;
        clrn = 1; #1;
        for (int i = 0; i < 17; i++) begin
            wwreg = 1; wm2reg = 0; wtemp = 1; wr = 32'(i);
            tick();
            total++; if (cnt2 !== 4'((i + 1) % 16)) begin
                bad++; $display("FAIL wrap_step%0d got=%0d exp=%0d", i, cnt2, (i + 1) % 16); end
        end
        wwreg = 0;
        total++; if (cnt2 !== 4'd1) begin bad++; $display("FAIL wrap_end got=%0d exp=1", cnt2); end
        total++; if (cnt0 !== 32'd17) begin bad++; $display("FAIL wide_17 got=%0d exp=17", cnt0); end
    endtask

    task automatic test_async_reset();
        for (int r = 8; r < 12; r++) begin
            wwreg = 1; wm2reg = 1; wtemp = 5'(r); wdo = $urandom | 32'h1;
            tick();
        end
        wwreg = 0; rna = 9; rnb = 10; dbg_rn = 11;
        #2;
        clrn = 0; model_clear();
        #1;
        total++; if (qa0 !== 32'd0 || qb0 !== 32'd0 || dbg0 !== 32'd0) begin
            bad++; $display("FAIL async_reads got=%h/%h/%h exp=0", qa0, qb0, dbg0); end
        total++; if (cnt0 !== 32'd0 || cnt2 !== 4'd0) begin
            bad++; $display("FAIL async_cnt got=%0d/%0d exp=0", cnt0, cnt2); end
        wwreg = 1; wm2reg = 0; wtemp = 9; wr = 32'hCAFE_F00D; rna = 9; dbg_rn = 9;
        #1;
        total++; if (qa0 !== 32'd0) begin bad++; $display("FAIL reset_no_bypass got=%h exp=0", qa0); end
        tick();
        wwreg = 0; #1;
        total++; if (dbg0 !== 32'd0 || cnt0 !== 32'd0) begin
            bad++; $display("FAIL reset_commit_dropped got=%h cnt=%0d exp=0", dbg0, cnt0); end
        clrn = 1;
        wwreg = 1; wtemp = 9; wr = 32'h600D_0009;
        tick();
        wwreg = 0; #1;
        total++; if (dbg0 !== 32'h600D_0009 || cnt0 !== 32'd1) begin
            bad++; $display("FAIL resume_commit got=%h cnt=%0d exp=600d0009 cnt=1", dbg0, cnt0); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 400; n++) begin
            wwreg  = ($urandom_range(0, 3) != 0);
            wm2reg = $urandom_range(0, 1) == 1;
            wtemp  = 5'($urandom_range(0, 31));
            wr     = $urandom;
            wdo    = $urandom;
            rna    = ($urandom_range(0, 2) == 0) ? wtemp : 5'($urandom_range(0, 31));
            rnb    = ($urandom_range(0, 2) == 0) ? wtemp : 5'($urandom_range(0, 31));
            dbg_rn = ($urandom_range(0, 1) == 0) ? wtemp : 5'($urandom_range(0, 31));
            #1;
            e = exp_read(rna, 1);
            total++; if (qa0 !== e || qa2 !== e) begin bad++; $display("FAIL rnd_qa n=%0d got=%h/%h exp=%h", n, qa0, qa2, e); end
            e = exp_read(rnb, 1);
            total++; if (qb0 !== e || qb2 !== e) begin bad++; $display("FAIL rnd_qb n=%0d got=%h/%h exp=%h", n, qb0, qb2, e); end
            total++; if (qa1 !== mem[rna] || qb1 !== mem[rnb]) begin
                bad++; $display("FAIL rnd_nobyp n=%0d got=%h/%h exp=%h/%h", n, qa1, qb1, mem[rna], mem[rnb]); end
            total++; if (dbg0 !== mem[dbg_rn] || dbg1 !== mem[dbg_rn]) begin
                bad++; $display("FAIL rnd_dbg n=%0d got=%h/%h exp=%h", n, dbg0, dbg1, mem[dbg_rn]); end
            total++; if (wd0 !== exp_wdata() || wd1 !== exp_wdata()) begin
                bad++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, wd0, exp_wdata()); end
            total++; if (cnt0 !== mcnt || cnt1 !== mcnt || cnt2 !== mcnt[3:0]) begin
                bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d/%0d exp=%0d", n, cnt0, cnt1, cnt2, mcnt); end
            tick();
        end
        wwreg = 0;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_bypass();
        test_reg_zero();
        test_no_bypass();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
